bram_multibuffer_ctrl: RTL and testbench

- Sequences `axis2bram_interface` fills across NUM_BUFFERS BRAM banks in ring order.
- Drives the writer's CTRL_ALLOW and selects the bank being filled; the bank index becomes the upper BRAM address bits.
- Latches each finished bank's DATA_DEPTH and hands completed banks, oldest first, to the accelerator (consumer).
- Stalls the writer when every bank is full and resumes when the consumer releases one.

---
 rtl/bram_multibuffer_ctrl_if.sv | 29 ++
 rtl/bram_multibuffer_ctrl.sv | 135 +++++++++++++
 tb/tb_bram_multibuffer_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_multibuffer_ctrl_if.sv
// Handshake bundle between the multibuffer controller, the axis2bram writer and the consumer.
// "master" is the controller side; "slave" is the integrator/writer/consumer side.
interface bram_multibuffer_ctrl_if #(
  parameter int BUF_IDX_WIDTH = 1,
  parameter int DEPTH_WIDTH   = 32
);
  logic                     ENABLE;
  logic                     WR_ALLOW;
  logic                     WR_FINISHED;
  logic [DEPTH_WIDTH-1:0]   WR_DEPTH;
  logic [BUF_IDX_WIDTH-1:0] WR_BUF_SEL;
  logic                     RD_VALID;
  logic [BUF_IDX_WIDTH-1:0] RD_BUF_SEL;
  logic [DEPTH_WIDTH-1:0]   RD_DEPTH;
  logic                     RD_DONE;
  logic                     FULL;
  logic                     EMPTY;
  logic [BUF_IDX_WIDTH:0]   OCCUPANCY;

  modport master (
    input  ENABLE, WR_FINISHED, WR_DEPTH, RD_DONE,
    output WR_ALLOW, WR_BUF_SEL, RD_VALID, RD_BUF_SEL, RD_DEPTH, FULL, EMPTY, OCCUPANCY
  );

  modport slave (
    output ENABLE, WR_FINISHED, WR_DEPTH, RD_DONE,
    input  WR_ALLOW, WR_BUF_SEL, RD_VALID, RD_BUF_SEL, RD_DEPTH, FULL, EMPTY, OCCUPANCY
  );
endinterface

// File: rtl/bram_multibuffer_ctrl.sv
// Ring-ordered fill sequencer and oldest-first hand-off for NUM_BUFFERS BRAM banks.
// Optional MBUF_STATS_EN adds FILL_COUNT / STALL_CYCLES statistics outputs.
module bram_multibuffer_ctrl #(
  parameter int NUM_BUFFERS   = 2,
  parameter int BUF_IDX_WIDTH = 1,
  parameter int DEPTH_WIDTH   = 32
) (
  input  logic                   ACC_CLK,
  input  logic                   ARESET,
`ifdef MBUF_STATS_EN
  output logic [31:0]            FILL_COUNT,
  output logic [31:0]            STALL_CYCLES,
`endif
  bram_multibuffer_ctrl_if.master bus
);

  localparam logic [BUF_IDX_WIDTH:0]   LP_NBUF = (BUF_IDX_WIDTH+1)'(NUM_BUFFERS);
  localparam logic [BUF_IDX_WIDTH:0]   LP_ONE  = (BUF_IDX_WIDTH+1)'(1);
  localparam logic [BUF_IDX_WIDTH-1:0] LP_LAST = BUF_IDX_WIDTH'(NUM_BUFFERS - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SWITCH} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [BUF_IDX_WIDTH-1:0] r_wr_ptr;
  logic [BUF_IDX_WIDTH-1:0] r_rd_ptr;
  logic [BUF_IDX_WIDTH:0]   r_count;
  logic [BUF_IDX_WIDTH:0]   w_count_nxt;
  logic [DEPTH_WIDTH-1:0]   r_depth [NUM_BUFFERS];
  logic                     r_wr_allow;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_full;

  // Explicit wrap compare so non-power-of-two bank counts never reach unused indices.
  function automatic logic [BUF_IDX_WIDTH-1:0] f_ptr_next(input logic [BUF_IDX_WIDTH-1:0] ptr);
    if (ptr == LP_LAST) begin
      return '0;
    end
    return ptr + BUF_IDX_WIDTH'(1);
  endfunction

  always_comb begin
    w_wr_acc = (r_state == W_FILL) && bus.WR_FINISHED;
    w_rd_acc = bus.RD_DONE && (r_count != '0);
    w_full   = (r_count == LP_NBUF);
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: begin
        if (bus.ENABLE && (r_count < LP_NBUF)) begin
          w_state_nxt = W_FILL;
        end
      end
      W_FILL: begin
        if (bus.WR_FINISHED) begin
          w_state_nxt = W_SWITCH;
        end
      end
      W_SWITCH: begin
        // Decide on the post-update count so a release in this cycle can resume filling.
        if (bus.ENABLE && (w_count_nxt < LP_NBUF)) begin
          w_state_nxt = W_FILL;
        end else begin
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACC_CLK) begin
    if (ARESET) begin
      r_state    <= W_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_allow <= 1'b0;
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        r_depth[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      // ALLOW lags FILL entry by one cycle and drops on the edge that accepts the done pulse.
      r_wr_allow <= (r_state == W_FILL) && (w_state_nxt == W_FILL);
      if (w_wr_acc) begin
        r_depth[r_wr_ptr] <= bus.WR_DEPTH;
        r_wr_ptr          <= f_ptr_next(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= f_ptr_next(r_rd_ptr);
      end
    end
  end

`ifdef MBUF_STATS_EN
  logic [31:0] r_fill_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge ACC_CLK) begin
    if (ARESET) begin
      r_fill_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_wr_acc) begin
        r_fill_count <= r_fill_count + 32'd1;
      end
      if ((r_state == W_IDLE) && bus.ENABLE && w_full) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign FILL_COUNT   = r_fill_count;
  assign STALL_CYCLES = r_stall_cycles;
`endif

  assign bus.WR_ALLOW   = r_wr_allow;
  assign bus.WR_BUF_SEL = r_wr_ptr;
  assign bus.RD_VALID   = (r_count != '0);
  assign bus.RD_BUF_SEL = r_rd_ptr;
  assign bus.RD_DEPTH   = r_depth[r_rd_ptr];
  assign bus.FULL       = w_full;
  assign bus.EMPTY      = (r_count == '0);
  assign bus.OCCUPANCY  = r_count;

endmodule

// File: tb/tb_bram_multibuffer_ctrl.sv
// Directed bench for bram_multibuffer_ctrl: a 2-bank instance for fill/stall/corner cases
// and a 3-bank instance for ring wrap; completed banks are tracked in scoreboard queues.
module tb_bram_multibuffer_ctrl;

  logic ACC_CLK = 1'b0;
  logic ARESET  = 1'b1;
  always #5 ACC_CLK = ~ACC_CLK;

  bram_multibuffer_ctrl_if #(.BUF_IDX_WIDTH(1), .DEPTH_WIDTH(32)) if2 ();
  bram_multibuffer_ctrl_if #(.BUF_IDX_WIDTH(2), .DEPTH_WIDTH(32)) if3 ();

`ifdef MBUF_STATS_EN
  logic [31:0] fill2, stall2, fill3, stall3;
`endif

  bram_multibuffer_ctrl #(.NUM_BUFFERS(2), .BUF_IDX_WIDTH(1), .DEPTH_WIDTH(32)) dut2 (
    .ACC_CLK      (ACC_CLK),
    .ARESET       (ARESET),
`ifdef MBUF_STATS_EN
    .FILL_COUNT   (fill2),
    .STALL_CYCLES (stall2),
`endif
    .bus          (if2)
  );

  bram_multibuffer_ctrl #(.NUM_BUFFERS(3), .BUF_IDX_WIDTH(2), .DEPTH_WIDTH(32)) dut3 (
    .ACC_CLK      (ACC_CLK),
    .ARESET       (ARESET),
`ifdef MBUF_STATS_EN
    .FILL_COUNT   (fill3),
    .STALL_CYCLES (stall3),
`endif
    .bus          (if3)
  );

  typedef struct packed {
    logic [1:0]  bank;
    logic [31:0] depth;
  } sb_t;

  sb_t q2[$];
  sb_t q3[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int m_wr, m_rd, m_cnt;

  task automatic tick();
    @(posedge ACC_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    if2.ENABLE = 0; if2.WR_FINISHED = 0; if2.WR_DEPTH = '0; if2.RD_DONE = 0;
    if3.ENABLE = 0; if3.WR_FINISHED = 0; if3.WR_DEPTH = '0; if3.RD_DONE = 0;
    tick();
    tick();
    ARESET = 1'b0;
    m_wr = 0; m_rd = 0; m_cnt = 0;
    q2.delete();
    q3.delete();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_allow"}, 64'(if2.WR_ALLOW),   64'd0);
    chk({tag, "_wsel"},  64'(if2.WR_BUF_SEL), 64'd0);
    chk({tag, "_valid"}, 64'(if2.RD_VALID),   64'd0);
    chk({tag, "_rsel"},  64'(if2.RD_BUF_SEL), 64'd0);
    chk({tag, "_depth"}, 64'(if2.RD_DEPTH),   64'd0);
    chk({tag, "_full"},  64'(if2.FULL),       64'd0);
    chk({tag, "_empty"}, 64'(if2.EMPTY),      64'd1);
    chk({tag, "_occ"},   64'(if2.OCCUPANCY),  64'd0);
`ifdef MBUF_STATS_EN
    chk({tag, "_fillcnt"},  64'(fill2),  64'd0);
    chk({tag, "_stallcnt"}, 64'(stall2), 64'd0);
`endif
  endtask

  task automatic occ2(input string tag);
    chk({tag, "_occ"},   64'(if2.OCCUPANCY),  64'(m_cnt));
    chk({tag, "_full"},  64'(if2.FULL),       64'(m_cnt == 2));
    chk({tag, "_empty"}, 64'(if2.EMPTY),      64'(m_cnt == 0));
    chk({tag, "_valid"}, 64'(if2.RD_VALID),   64'(m_cnt != 0));
    chk({tag, "_wsel"},  64'(if2.WR_BUF_SEL), 64'(m_wr));
  endtask

  task automatic finish2(input logic [31:0] d);
    if2.WR_FINISHED = 1'b1;
    if2.WR_DEPTH    = d;
    q2.push_back('{bank: 2'(m_wr), depth: d});
    m_wr  = (m_wr + 1) % 2;
    m_cnt = m_cnt + 1;
    tick();
    if2.WR_FINISHED = 1'b0;
    if2.WR_DEPTH    = '0;
  endtask

  task automatic release2(input string tag);
    sb_t e;
    if (q2.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(q2.size()), 64'd1);
    end else begin
      e = q2.pop_front();
      chk({tag, "_rsel"},  64'(if2.RD_BUF_SEL), 64'(e.bank));
      chk({tag, "_depth"}, 64'(if2.RD_DEPTH),   64'(e.depth));
      if2.RD_DONE = 1'b1;
      tick();
      if2.RD_DONE = 1'b0;
      m_rd  = (m_rd + 1) % 2;
      m_cnt = m_cnt - 1;
    end
  endtask

  initial begin
    sb_t e;
    int  n;
    do_reset();
    ARESET = 1'b1;
    tick();
    rst_chk("reset");
    ARESET = 1'b0;

    // Fill and release
    if2.ENABLE = 1'b1;
    tick();
    chk("fr_entry_allow", 64'(if2.WR_ALLOW), 64'd0);
    tick();
    chk("fr_allow_high", 64'(if2.WR_ALLOW), 64'd1);
    chk("fr_wsel0", 64'(if2.WR_BUF_SEL), 64'd0);
    finish2(32'd64);
    chk("fr_allow_low1", 64'(if2.WR_ALLOW), 64'd0);
    occ2("fr_after_done");
    chk("fr_rsel", 64'(if2.RD_BUF_SEL), 64'(q2[0].bank));
    chk("fr_rdepth", 64'(if2.RD_DEPTH), 64'(q2[0].depth));
    tick();
    chk("fr_allow_low2", 64'(if2.WR_ALLOW), 64'd0);
    tick();
    chk("fr_allow_back", 64'(if2.WR_ALLOW), 64'd1);
    chk("fr_wsel1", 64'(if2.WR_BUF_SEL), 64'd1);

    // Full stall
    do_reset();
    if2.ENABLE = 1'b1;
    tick();
    tick();
    finish2(32'd16);
    tick();
    tick();
    chk("st_allow_b1", 64'(if2.WR_ALLOW), 64'd1);
    chk("st_wsel_b1", 64'(if2.WR_BUF_SEL), 64'd1);
    finish2(32'd32);
    occ2("st_full");
    chk("st_allow_off", 64'(if2.WR_ALLOW), 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("st_stall_allow%0d", i), 64'(if2.WR_ALLOW), 64'd0);
    end
`ifdef MBUF_STATS_EN
    chk("st_stall_cycles", 64'(stall2), 64'd10);
    chk("st_fill_count", 64'(fill2), 64'd2);
`endif
    release2("st_rel0");
    chk("st_next_rsel", 64'(if2.RD_BUF_SEL), 64'd1);
    chk("st_next_depth", 64'(if2.RD_DEPTH), 64'd32);
    chk("st_rel_allow0", 64'(if2.WR_ALLOW), 64'd0);
    tick();
    chk("st_rel_allow1", 64'(if2.WR_ALLOW), 64'd0);
    tick();
    chk("st_resume_allow", 64'(if2.WR_ALLOW), 64'd1);
    chk("st_resume_wsel", 64'(if2.WR_BUF_SEL), 64'd0);

    // Simultaneous finish and release
    e = q2.pop_front();
    chk("sim_pre_rsel", 64'(if2.RD_BUF_SEL), 64'(e.bank));
    chk("sim_pre_depth", 64'(if2.RD_DEPTH), 64'(e.depth));
    q2.push_back('{bank: 2'(m_wr), depth: 32'd48});
    if2.WR_FINISHED = 1'b1;
    if2.WR_DEPTH    = 32'd48;
    if2.RD_DONE     = 1'b1;
    tick();
    if2.WR_FINISHED = 1'b0;
    if2.RD_DONE     = 1'b0;
    m_wr = (m_wr + 1) % 2;
    m_rd = (m_rd + 1) % 2;
    occ2("sim");
    chk("sim_rsel", 64'(if2.RD_BUF_SEL), 64'(q2[0].bank));
    chk("sim_rdepth", 64'(if2.RD_DEPTH), 64'(q2[0].depth));

    // Spurious inputs
    if2.ENABLE = 1'b0;
    tick();
    if2.WR_FINISHED = 1'b1;
    if2.WR_DEPTH    = 32'd99;
    tick();
    if2.WR_FINISHED = 1'b0;
    occ2("spur_idle_fin");
    chk("spur_idle_allow", 64'(if2.WR_ALLOW), 64'd0);
    release2("spur_rel");
    occ2("spur_emptied");
    if2.RD_DONE = 1'b1;
    tick();
    if2.RD_DONE = 1'b0;
    occ2("spur_rd_empty");
    chk("spur_rd_empty_rsel", 64'(if2.RD_BUF_SEL), 64'(m_rd));

    // ENABLE dropped mid-fill
    if2.ENABLE = 1'b1;
    tick();
    tick();
    chk("en_allow", 64'(if2.WR_ALLOW), 64'd1);
    if2.ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("en_hold%0d", i), 64'(if2.WR_ALLOW), 64'd1);
    end
    finish2(32'd20);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("en_parked%0d", i), 64'(if2.WR_ALLOW), 64'd0);
    end
    occ2("en_parked");
    release2("en_rel");

    // Reset mid-fill
    if2.ENABLE = 1'b1;
    tick();
    tick();
    chk("rmf_allow", 64'(if2.WR_ALLOW), 64'd1);
    ARESET = 1'b1;
    tick();
    rst_chk("rmf");
    do_reset();

    // Ring wrap on the 3-bank instance
    if3.ENABLE = 1'b1;
    m_wr = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!if3.WR_ALLOW && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("wrap_allow%0d", i), 64'(if3.WR_ALLOW), 64'd1);
      chk($sformatf("wrap_wsel%0d", i), 64'(if3.WR_BUF_SEL), 64'(i % 3));
      q3.push_back('{bank: 2'(m_wr), depth: 32'(i * 8 + 8)});
      m_wr = (m_wr + 1) % 3;
      if3.WR_FINISHED = 1'b1;
      if3.WR_DEPTH    = 32'(i * 8 + 8);
      tick();
      if3.WR_FINISHED = 1'b0;
      e = q3.pop_front();
      chk($sformatf("wrap_rsel%0d", i), 64'(if3.RD_BUF_SEL), 64'(e.bank));
      chk($sformatf("wrap_rdepth%0d", i), 64'(if3.RD_DEPTH), 64'(e.depth));
      if3.RD_DONE = 1'b1;
      tick();
      if3.RD_DONE = 1'b0;
      chk($sformatf("wrap_occ%0d", i), 64'(if3.OCCUPANCY), 64'd0);
    end
    chk("wrap_final_wsel", 64'(if3.WR_BUF_SEL), 64'(m_wr));
    if3.ENABLE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
